// File: rtl/uart_axi_pkg.sv
// Shared constants and CRC-8 helper for the host UART <-> AXI bridge.
// Used by the response framer and by any bench that models its frames.
package uart_axi_pkg;

  localparam int          MAX_DATA_BYTES = 64;
  localparam logic [6:0]  DATA_CNT_MAX   = 7'(MAX_DATA_BYTES);

  localparam logic [7:0]  SOF_H2D        = 8'h5A;
  localparam logic [7:0]  SOF_D2H        = 8'hA5;

  localparam logic [7:0]  STATUS_OK      = 8'h00;
  localparam logic [7:0]  STATUS_BUS_ERR = 8'h01;
  localparam logic [7:0]  STATUS_BAD_LEN = 8'h02;

  localparam int          CMD_READ_BIT   = 7;

  // CRC-8, poly 0x07, MSB-first, no reflection, no final XOR.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = {c[6:0], 1'b0} ^ (c[7] ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [6:0] clamp_count(input logic [6:0] n);
    return (n > DATA_CNT_MAX) ? DATA_CNT_MAX : n;
  endfunction

endpackage

// File: rtl/uart_response_framer_if.sv
// Transaction-result request side plus TX FIFO write side of the response framer.
interface uart_response_framer_if;
  import uart_axi_pkg::*;

  logic        resp_start;
  logic [7:0]  resp_status;
  logic [7:0]  resp_cmd;
  logic [31:0] resp_addr;
  logic [7:0]  resp_data [MAX_DATA_BYTES];
  logic [6:0]  resp_data_count;
  logic        tx_fifo_full;
  logic [7:0]  tx_fifo_data;
  logic        tx_fifo_wr_en;
  logic        resp_busy;
  logic        resp_done;

  modport master (
    output resp_start, resp_status, resp_cmd, resp_addr, resp_data, resp_data_count,
    output tx_fifo_full,
    input  tx_fifo_data, tx_fifo_wr_en, resp_busy, resp_done
  );

  modport slave (
    input  resp_start, resp_status, resp_cmd, resp_addr, resp_data, resp_data_count,
    input  tx_fifo_full,
    output tx_fifo_data, tx_fifo_wr_en, resp_busy, resp_done
  );
endinterface

// File: rtl/uart_response_framer.sv
// Serialises one transaction result into a SOF..CRC-8 response frame, one byte
// per cycle into the UART TX FIFO, stalling while the FIFO is full.
module uart_response_framer
  import uart_axi_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  uart_response_framer_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_STATUS, S_CMD,
    S_ADDR0, S_ADDR1, S_ADDR2, S_ADDR3,
    S_DATA, S_CRC, S_DONE
  } state_e;

  state_e      r_state, w_next;
  logic [7:0]  r_status, r_cmd, r_crc;
  logic [31:0] r_addr;
  logic [7:0]  r_data [MAX_DATA_BYTES];
  logic [6:0]  r_count, r_idx;

  logic        w_accept, w_ready, w_payload, w_emit, w_covered, w_write;
  logic [7:0]  w_byte;

  assign w_accept  = (r_state == S_IDLE) && bus.resp_start;
  assign w_ready   = !bus.tx_fifo_full;
  assign w_payload = r_cmd[CMD_READ_BIT] && (r_status == STATUS_OK);
  assign w_write   = w_emit && w_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: defaults first; any path that skipped an assignment would infer a latch.
    w_next    = r_state;
    w_emit    = 1'b0;
    w_covered = 1'b0;
    w_byte    = 8'h00;
    case (r_state)
      S_IDLE:   if (bus.resp_start) w_next = S_SOF;
      S_SOF:    begin w_emit = 1'b1; w_byte = SOF_D2H;
                  if (w_ready) w_next = S_STATUS; end
      S_STATUS: begin w_emit = 1'b1; w_covered = 1'b1; w_byte = r_status;
                  if (w_ready) w_next = S_CMD; end
      S_CMD:    begin w_emit = 1'b1; w_covered = 1'b1; w_byte = r_cmd;
                  if (w_ready) w_next = w_payload ? S_ADDR0 : S_CRC; end
      S_ADDR0:  begin w_emit = 1'b1; w_covered = 1'b1; w_byte = r_addr[7:0];
                  if (w_ready) w_next = S_ADDR1; end
      S_ADDR1:  begin w_emit = 1'b1; w_covered = 1'b1; w_byte = r_addr[15:8];
                  if (w_ready) w_next = S_ADDR2; end
      S_ADDR2:  begin w_emit = 1'b1; w_covered = 1'b1; w_byte = r_addr[23:16];
                  if (w_ready) w_next = S_ADDR3; end
      S_ADDR3:  begin w_emit = 1'b1; w_covered = 1'b1; w_byte = r_addr[31:24];
                  if (w_ready) w_next = (r_count == 7'd0) ? S_CRC : S_DATA; end
      S_DATA:   begin w_emit = 1'b1; w_covered = 1'b1; w_byte = r_data[r_idx[5:0]];
                  if (w_ready && (r_idx == r_count - 7'd1)) w_next = S_CRC; end
      S_CRC:    begin w_emit = 1'b1; w_byte = r_crc;
                  if (w_ready) w_next = S_DONE; end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_status <= 8'h00;
      r_cmd    <= 8'h00;
      r_addr   <= 32'h0;
      r_count  <= 7'd0;
      r_idx    <= 7'd0;
      r_crc    <= 8'h00;
    end else if (w_accept) begin
      r_status <= bus.resp_status;
      r_cmd    <= bus.resp_cmd;
      r_addr   <= bus.resp_addr;
      r_count  <= clamp_count(bus.resp_data_count);
      r_idx    <= 7'd0;
      r_crc    <= 8'h00;
    end else if (w_write) begin
      if (w_covered)          r_crc <= crc8_update(r_crc, w_byte);
      if (r_state == S_DATA)  r_idx <= r_idx + 7'd1;
    end
  end

  // NOTE: the payload buffer is never read before a frame is accepted, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < MAX_DATA_BYTES; i++) r_data[i] <= bus.resp_data[i];
    end
  end

  assign bus.tx_fifo_data  = w_byte;
  assign bus.tx_fifo_wr_en = w_write;
  assign bus.resp_busy     = (r_state != S_IDLE);
  assign bus.resp_done     = (r_state == S_DONE);

endmodule
